// File: rtl/turbo_pkg.sv
// Shared sizing and state definitions for the turbo encoder block.
// The wrapper and interleaver import this too, so block lengths stay identical everywhere.
package turbo_pkg;

    localparam int K_SMALL  = 1056;
    localparam int K_LARGE  = 6144;
    localparam int CNT_W    = 13;
    localparam int TAIL_LEN = 3;
    localparam int TAIL_W   = $clog2(TAIL_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_TAIL1 = 3'd3,
        ST_TAIL2 = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] k_of(input logic k_sel);
        return k_sel ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
    endfunction

endpackage

// File: rtl/turbo_tail_cnt.sv
// Down-counter for trellis termination cycles.
// A load sets it to LEN-1, so zero_o marks the last counted cycle of a tail.
module turbo_tail_cnt
    import turbo_pkg::*;
#(
    parameter int LEN = TAIL_LEN,
    parameter int W   = TAIL_W
) (
    input  logic clk,
    input  logic aclr,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LEN - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Code-block sequencer: lockstep reads of both sources for K bits,
// then termination of encoder 1 followed by encoder 2.
module turbo_enc_ctrl
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic             k_sel,
    output logic             ready,
    input  logic             src1_empty,
    input  logic             src2_valid,
    input  logic             out_ready,
    output logic             rd_req,
    output logic             enc_en,
    output logic             enc1_term,
    output logic             enc2_term,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             enc_en_q;
    logic             tail_load, tail_en, tail_zero;
    logic             src_ok;

    // Both sources must offer a bit and the sink must take it; otherwise neither advances.
    assign src_ok = !src1_empty && src2_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        k_d       = k_q;
        ready     = 1'b0;
        rd_req    = 1'b0;
        enc1_term = 1'b0;
        enc2_term = 1'b0;
        done      = 1'b0;
        tail_load = 1'b0;
        tail_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    k_d       = k_of(k_sel);
                    bit_cnt_d = '0;
                    state_d   = ST_ENC;
                end
            end
            ST_ENC: begin
                rd_req = src_ok;
                if (src_ok) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == k_q - CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                tail_load = 1'b1;
                state_d   = ST_TAIL1;
            end
            ST_TAIL1: begin
                enc1_term = out_ready;
                tail_en   = out_ready;
                if (out_ready && tail_zero) begin
                    tail_load = 1'b1;
                    state_d   = ST_TAIL2;
                end
            end
            ST_TAIL2: begin
                enc2_term = out_ready;
                tail_en   = out_ready;
                if (out_ready && tail_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            k_q       <= CNT_W'(K_SMALL);
            enc_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            k_q       <= k_d;
            enc_en_q  <= rd_req;
        end
    end

    // Single counter reused for both tails; reloaded on FLUSH->TAIL1 and TAIL1->TAIL2.
    turbo_tail_cnt #(
        .LEN (TAIL_LEN),
        .W   (TAIL_W)
    ) u_tail_cnt (
        .clk    (clk),
        .aclr   (aclr),
        .load_i (tail_load),
        .en_i   (tail_en),
        .zero_o (tail_zero)
    );

    assign enc_en  = enc_en_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Bench for turbo_enc_ctrl: per-cycle comparison against a counting model,
// plus literal timing checks for the directed block scenarios.
module tb_turbo_enc_ctrl;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        start = 1'b0;
    logic        k_sel = 1'b0;
    logic        src1_empty = 1'b0;
    logic        src2_valid = 1'b1;
    logic        out_ready = 1'b1;
    logic        ready, rd_req, enc_en, enc1_term, enc2_term, done;
    logic [12:0] bit_cnt;

    turbo_enc_ctrl dut (
        .clk        (clk),
        .aclr       (aclr),
        .start      (start),
        .k_sel      (k_sel),
        .ready      (ready),
        .src1_empty (src1_empty),
        .src2_valid (src2_valid),
        .out_ready  (out_ready),
        .rd_req     (rd_req),
        .enc_en     (enc_en),
        .enc1_term  (enc1_term),
        .enc2_term  (enc2_term),
        .bit_cnt    (bit_cnt),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: block progress expressed as counts of bits read and tail beats taken.
    bit m_busy = 1'b0;
    bit m_flushed = 1'b0;
    bit m_prev_rd = 1'b0;
    int m_k = 1056;
    int m_nbits = 0;
    int m_tails = 0;

    // Observed DUT activity per block: index 0 rd_req, 1 enc_en, 2 enc1_term, 3 enc2_term.
    int cyc = 0;
    int blk_start = 0, prev_acc = 0, done_rel = -1, done_abs = -1, viol = 0;
    int first_c[4], last_c[4], cnt_c[4];

    always @(negedge clk) begin
        bit e_rd, e_flush, e_t1, e_t2, e_done;
        bit obs[4];
        int rel;
        cyc++;
        if (aclr) begin
            m_busy = 0; m_flushed = 0; m_prev_rd = 0;
            m_k = 1056; m_nbits = 0; m_tails = 0;
        end
        e_rd    = !aclr && m_busy && (m_nbits < m_k) && !src1_empty && src2_valid && out_ready;
        e_flush = m_busy && (m_nbits == m_k) && !m_flushed;
        e_t1    = m_busy && m_flushed && (m_tails < 3) && out_ready;
        e_t2    = m_busy && m_flushed && (m_tails >= 3) && (m_tails < 6) && out_ready;
        e_done  = m_busy && (m_tails == 6);
        chk("ready",     ready,     !m_busy);
        chk("rd_req",    rd_req,    e_rd);
        chk("enc_en",    enc_en,    m_prev_rd);
        chk("enc1_term", enc1_term, e_t1);
        chk("enc2_term", enc2_term, e_t2);
        chk("done",      done,      e_done);
        chk("bit_cnt",   bit_cnt,   m_nbits);

        if (!aclr) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_k = k_sel ? 6144 : 1056;
                    m_nbits = 0; m_flushed = 0; m_tails = 0;
                end
            end else if (e_rd) m_nbits++;
            else if (e_flush) m_flushed = 1;
            else if (m_flushed && m_tails < 6 && out_ready) m_tails++;
            else if (e_done) m_busy = 0;
        end
        m_prev_rd = e_rd;

        if (!aclr && ready && start) begin
            prev_acc = blk_start; blk_start = cyc;
            done_rel = -1; viol = 0;
            for (int i = 0; i < 4; i++) begin first_c[i] = -1; last_c[i] = -1; cnt_c[i] = 0; end
        end
        rel = cyc - blk_start;
        obs[0] = rd_req; obs[1] = enc_en; obs[2] = enc1_term; obs[3] = enc2_term;
        for (int i = 0; i < 4; i++) begin
            if (obs[i]) begin
                if (first_c[i] < 0) first_c[i] = rel;
                last_c[i] = rel;
                cnt_c[i]++;
            end
        end
        if (rd_req && !src2_valid) viol++;
        if (done) begin done_rel = rel; done_abs = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input logic ks);
        start = 1'b1; k_sel = ks;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit got = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; break; end
        end
        if (!got) chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        // 1) reset state
        repeat (3) @(posedge clk);
        #1 aclr = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_enc_en", enc_en, 0);
        chk("rst_term", {enc1_term, enc2_term}, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        tick();

        // 2) small block, no stalls
        start_blk(1'b0);
        wait_done(3000);
        chk("t2_n_rd", cnt_c[0], 1056);
        chk("t2_first_rd", first_c[0], 1);
        chk("t2_last_rd", last_c[0], 1056);
        chk("t2_first_en", first_c[1], 2);
        chk("t2_last_en", last_c[1], 1057);
        chk("t2_first_t1", first_c[2], 1058);
        chk("t2_last_t1", last_c[2], 1060);
        chk("t2_first_t2", first_c[3], 1061);
        chk("t2_last_t2", last_c[3], 1063);
        chk("t2_done", done_rel, 1064);
        chk("t2_bit_cnt_hold", bit_cnt, 1056);

        // 3) large block, interleaver valid toggling
        start_blk(1'b1);
        begin
            bit got = 0;
            for (int i = 0; i < 20000; i++) begin
                src2_valid = ~src2_valid;
                @(negedge clk);
                if (done === 1'b1) begin got = 1; break; end
                @(posedge clk); #1;
            end
            if (!got) chk("t3_timeout", 0, 1);
            tick();
        end
        src2_valid = 1'b1;
        chk("t3_n_rd", cnt_c[0], 6144);
        chk("t3_bit_cnt", bit_cnt, 6144);
        chk("t3_rd_while_invalid", viol, 0);

        // 4) out_ready stall inside TAIL1
        start_blk(1'b0);
        repeat (1058) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done(3000);
        chk("t4_n_t1", cnt_c[2], 3);
        chk("t4_first_t1", first_c[2], 1058);
        chk("t4_last_t1", last_c[2], 1065);
        chk("t4_n_t2", cnt_c[3], 3);
        chk("t4_done", done_rel, 1069);

        // 5) start ignored in ENC and DONE, accepted the cycle after done
        start_blk(1'b0);
        repeat (99) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (963) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        chk("t5_first_done", done_abs - prev_acc, 1064);
        chk("t5_reaccept", blk_start - prev_acc, 1065);
        wait_done(3000);
        chk("t5_n_rd", cnt_c[0], 1056);

        // 6) aclr mid-block, then a clean block
        start_blk(1'b0);
        begin
            bit got = 0;
            for (int i = 0; i < 2000; i++) begin
                @(posedge clk); #1;
                if (bit_cnt == 13'd500) begin got = 1; break; end
            end
            if (!got) chk("t6_timeout", 0, 1);
        end
        aclr = 1'b1;
        #1;
        chk("t6_ready", ready, 1);
        chk("t6_rd_req", rd_req, 0);
        chk("t6_enc_en", enc_en, 0);
        chk("t6_bit_cnt", bit_cnt, 0);
        tick();
        aclr = 1'b0;
        tick();
        start_blk(1'b0);
        wait_done(3000);
        chk("t6_n_rd", cnt_c[0], 1056);
        chk("t6_done", done_rel, 1064);

        // 7) random sources, sink and spurious starts
        for (int i = 0; i < 6000; i++) begin
            src1_empty = ($urandom_range(0, 4) == 0);
            src2_valid = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 8);
            start      = ($urandom_range(0, 49) == 0);
            k_sel      = 1'b0;
            tick();
        end
        start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
